// File: rtl/tx_a_pkt_arbiter.sv
// tx_a_pkt_arbiter: packet-atomic round-robin merge of NUM_SRC streams onto TX-A, with posted-write commit tracking.
// Latency: 1 cycle from input acceptance to out_tvalid (single registered output stage).
// Backpressure: in_tready only to the granted/locked source while the output slot is free; write sources stall at MAX_WR_OUTSTANDING (TX_A_ARB_MMIO_PRIO_EN: source 0 strict priority).
module tx_a_pkt_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DATA_W = 512,
    parameter int USER_W = 10,
    parameter logic [NUM_SRC-1:0] WR_SRC_MASK = 3'b010,
    parameter int MAX_WR_OUTSTANDING = 64,
    localparam int KEEP_W = DATA_W / 8,
    localparam int CNT_W = $clog2(MAX_WR_OUTSTANDING + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          in_tvalid,
    input  logic [NUM_SRC-1:0]          in_tlast,
    input  logic [NUM_SRC*DATA_W-1:0]   in_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0]   in_tkeep,
    input  logic [NUM_SRC*USER_W-1:0]   in_tuser,
    output logic [NUM_SRC-1:0]          in_tready,
    output logic                        out_tvalid,
    output logic                        out_tlast,
    output logic [DATA_W-1:0]           out_tdata,
    output logic [KEEP_W-1:0]           out_tkeep,
    output logic [USER_W-1:0]           out_tuser,
    input  logic                        out_tready,
    input  logic                        rx_commit_tvalid,
    output logic                        rx_commit_tready,
    output logic [CNT_W-1:0]            wr_outstanding,
    output logic                        err_commit_underflow
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WR_OUTSTANDING);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   lock_idx;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   sel;
    logic               grant_found;
    logic               sel_vld;
    logic               out_en;
    logic               accept;
    logic               wr_inc;
    logic               wr_room;
    logic [NUM_SRC-1:0] eligible;

    logic               sel_tvalid;
    logic               sel_tlast;
    logic               sel_wr;
    logic [DATA_W-1:0]  sel_tdata;
    logic [KEEP_W-1:0]  sel_tkeep;
    logic [USER_W-1:0]  sel_tuser;

    assign rx_commit_tready = 1'b1;
    assign wr_room = (wr_outstanding < MAX_CNT);
    assign out_en  = !out_tvalid || out_tready;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = in_tvalid[i] && (!WR_SRC_MASK[i] || wr_room);
        end
    end

    // Round-robin: sources above last_grant first, then wrap to the lowest index.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
`ifdef TX_A_ARB_MMIO_PRIO_EN
        if (eligible[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end
`endif
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!grant_found && eligible[i] && (IDX_W'(i) > last_grant)) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!grant_found && eligible[i]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

    assign sel     = (state == LOCKED) ? lock_idx : grant_idx;
    assign sel_vld = (state == LOCKED) || grant_found;

    always_comb begin
        in_tready  = '0;
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_wr     = 1'b0;
        sel_tdata  = '0;
        sel_tkeep  = '0;
        sel_tuser  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (IDX_W'(i) == sel) begin
                in_tready[i] = sel_vld && out_en && !rst;
                sel_tvalid   = in_tvalid[i];
                sel_tlast    = in_tlast[i];
                sel_wr       = WR_SRC_MASK[i];
                sel_tdata    = in_tdata[i*DATA_W +: DATA_W];
                sel_tkeep    = in_tkeep[i*KEEP_W +: KEEP_W];
                sel_tuser    = in_tuser[i*USER_W +: USER_W];
            end
        end
    end

    assign accept = sel_vld && out_en && !rst && sel_tvalid;
    assign wr_inc = accept && (state == IDLE) && sel_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            last_grant           <= LAST_IDX;
            lock_idx             <= '0;
            out_tvalid           <= 1'b0;
            wr_outstanding       <= '0;
            err_commit_underflow <= 1'b0;
        end else begin
            if (accept) begin
                out_tvalid <= 1'b1;
                if (state == IDLE) begin
                    last_grant <= sel;
                    if (!sel_tlast) begin
                        state    <= LOCKED;
                        lock_idx <= sel;
                    end
                end else if (sel_tlast) begin
                    state <= IDLE;
                end
            end else if (out_tready) begin
                out_tvalid <= 1'b0;
            end

            // Commit with nothing outstanding is a protocol error; the count saturates at zero.
            if (wr_inc && !rx_commit_tvalid) begin
                wr_outstanding <= wr_outstanding + 1'b1;
            end else if (!wr_inc && rx_commit_tvalid) begin
                if (wr_outstanding == '0) begin
                    err_commit_underflow <= 1'b1;
                end else begin
                    wr_outstanding <= wr_outstanding - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            out_tlast <= sel_tlast;
            out_tdata <= sel_tdata;
            out_tkeep <= sel_tkeep;
            out_tuser <= sel_tuser;
        end
    end

endmodule

// File: tb/tb_tx_a_pkt_arbiter.sv
// Directed bench for tx_a_pkt_arbiter: round-robin, atomicity, write limit, underflow, backpressure, reset, priority.
module tb_tx_a_pkt_arbiter;

    localparam int NS = 3;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     in_tvalid, in_tlast;
    logic [NS*DW-1:0]  in_tdata;
    logic [NS*KW-1:0]  in_tkeep;
    logic [NS*UW-1:0]  in_tuser;
    logic              out_tready, rx_commit_tvalid;

    logic [NS-1:0]     in_tready, in_tready_b;
    logic              out_tvalid, out_tlast, out_tvalid_b, out_tlast_b;
    logic [DW-1:0]     out_tdata, out_tdata_b;
    logic [KW-1:0]     out_tkeep, out_tkeep_b;
    logic [UW-1:0]     out_tuser, out_tuser_b;
    logic              rx_commit_tready, rx_commit_tready_b;
    logic [6:0]        wr_outstanding;
    logic [1:0]        wr_outstanding_b;
    logic              err_commit_underflow, err_commit_underflow_b;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tx_a_pkt_arbiter dut (
        .clk(clk), .rst(rst),
        .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tdata(in_tdata),
        .in_tkeep(in_tkeep), .in_tuser(in_tuser), .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tdata(out_tdata),
        .out_tkeep(out_tkeep), .out_tuser(out_tuser), .out_tready(out_tready),
        .rx_commit_tvalid(rx_commit_tvalid), .rx_commit_tready(rx_commit_tready),
        .wr_outstanding(wr_outstanding), .err_commit_underflow(err_commit_underflow)
    );

    tx_a_pkt_arbiter #(.MAX_WR_OUTSTANDING(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tdata(in_tdata),
        .in_tkeep(in_tkeep), .in_tuser(in_tuser), .in_tready(in_tready_b),
        .out_tvalid(out_tvalid_b), .out_tlast(out_tlast_b), .out_tdata(out_tdata_b),
        .out_tkeep(out_tkeep_b), .out_tuser(out_tuser_b), .out_tready(out_tready),
        .rx_commit_tvalid(rx_commit_tvalid), .rx_commit_tready(rx_commit_tready_b),
        .wr_outstanding(wr_outstanding_b), .err_commit_underflow(err_commit_underflow_b)
    );

    function automatic logic [UW-1:0] tg(input int s, input int b);
        return UW'(s * 64 + b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic v, input logic l, input logic [UW-1:0] tag);
        logic [31:0] word;
        word = {22'b0, tag};
        in_tvalid[s] = v;
        in_tlast[s]  = l;
        in_tdata[s*DW +: DW] = {(DW/32){word}};
        in_tkeep[s*KW +: KW] = '1;
        in_tuser[s*UW +: UW] = tag;
    endtask

    task automatic clear_inputs();
        in_tvalid = '0;
        in_tlast = '0;
        in_tdata = '0;
        in_tkeep = '0;
        in_tuser = '0;
        rx_commit_tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_tready = 1'b1;
        for (int s = 0; s < NS; s++) set_src(s, 1'b1, 1'b1, tg(s, 0));
        rx_commit_tvalid = 1'b1;
        tick();
        tick();
        n_checks++; if (in_tready !== 3'b000) begin n_fail++; $display("FAIL reset_rdy: got %b want 000", in_tready); end
        n_checks++; if (out_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_out_tvalid: got %b want 0", out_tvalid); end
        n_checks++; if (wr_outstanding !== 7'd0) begin n_fail++; $display("FAIL reset_wr: got %0d want 0", wr_outstanding); end
        n_checks++; if (err_commit_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_commit_underflow); end
        n_checks++; if (rx_commit_tready !== 1'b1) begin n_fail++; $display("FAIL commit_tready: got %b want 1", rx_commit_tready); end
        n_checks++; if (in_tready_b !== 3'b000) begin n_fail++; $display("FAIL reset_rdy_b: got %b want 000", in_tready_b); end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int e;
        logic [NS-1:0] exp_rdy;
        do_reset();
        out_tready = 1'b1;
        for (int s = 0; s < NS; s++) set_src(s, 1'b1, 1'b1, tg(s, 0));
        for (int n = 0; n < 6; n++) begin
            e = n % 3;
            exp_rdy = 3'b001 << e;
            #1;
            n_checks++; if (in_tready !== exp_rdy) begin n_fail++; $display("FAIL rr_rdy n%0d: got %b want %b", n, in_tready, exp_rdy); end
            tick();
            n_checks++; if (out_tvalid !== 1'b1 || out_tuser !== tg(e, 0)) begin n_fail++; $display("FAIL rr_out n%0d: got v=%b u=%0d want v=1 u=%0d", n, out_tvalid, out_tuser, tg(e, 0)); end
            n_checks++; if (out_tdata[31:0] !== {22'b0, tg(e, 0)} || out_tlast !== 1'b1) begin n_fail++; $display("FAIL rr_data n%0d: got d=%h l=%b want d=%h l=1", n, out_tdata[31:0], out_tlast, {22'b0, tg(e, 0)}); end
        end
        n_checks++; if (out_tkeep !== {KW{1'b1}}) begin n_fail++; $display("FAIL rr_keep: got %h want all ones", out_tkeep); end
        clear_inputs();
        tick();
        n_checks++; if (out_tvalid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b want 0", out_tvalid); end
    endtask

    task automatic test_atomic();
        do_reset();
        out_tready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            set_src(1, 1'b1, (b == 3), tg(1, b));
            if (b >= 2) set_src(0, 1'b1, 1'b1, tg(0, 0));
            #1;
            n_checks++; if (in_tready !== 3'b010) begin n_fail++; $display("FAIL atomic_rdy b%0d: got %b want 010", b, in_tready); end
            tick();
            n_checks++; if (out_tuser !== tg(1, b) || out_tlast !== (b == 3)) begin n_fail++; $display("FAIL atomic_out b%0d: got u=%0d l=%b want u=%0d l=%b", b, out_tuser, out_tlast, tg(1, b), (b == 3)); end
        end
        set_src(1, 1'b0, 1'b0, '0);
        #1;
        n_checks++; if (in_tready !== 3'b001) begin n_fail++; $display("FAIL atomic_next_rdy: got %b want 001", in_tready); end
        tick();
        n_checks++; if (out_tuser !== tg(0, 0)) begin n_fail++; $display("FAIL atomic_next_out: got %0d want %0d", out_tuser, tg(0, 0)); end
        clear_inputs();
    endtask

    task automatic test_wr_limit();
        do_reset();
        out_tready = 1'b1;
        set_src(1, 1'b1, 1'b1, tg(1, 0));
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (in_tready_b !== 3'b010) begin n_fail++; $display("FAIL wrlim_rdy k%0d: got %b want 010", k, in_tready_b); end
            tick();
            n_checks++; if (wr_outstanding_b !== 2'(k + 1)) begin n_fail++; $display("FAIL wrlim_cnt k%0d: got %0d want %0d", k, wr_outstanding_b, k + 1); end
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++; if (in_tready_b !== 3'b000) begin n_fail++; $display("FAIL wrlim_stall_rdy k%0d: got %b want 000", k, in_tready_b); end
            tick();
            n_checks++; if (wr_outstanding_b !== 2'd2 || out_tvalid_b !== 1'b0) begin n_fail++; $display("FAIL wrlim_stall k%0d: got cnt=%0d v=%b want cnt=2 v=0", k, wr_outstanding_b, out_tvalid_b); end
        end
        rx_commit_tvalid = 1'b1;
        #1;
        n_checks++; if (in_tready_b !== 3'b000) begin n_fail++; $display("FAIL wrlim_commit_rdy: got %b want 000", in_tready_b); end
        tick();
        rx_commit_tvalid = 1'b0;
        n_checks++; if (wr_outstanding_b !== 2'd1) begin n_fail++; $display("FAIL wrlim_after_commit: got %0d want 1", wr_outstanding_b); end
        #1;
        n_checks++; if (in_tready_b !== 3'b010) begin n_fail++; $display("FAIL wrlim_resume_rdy: got %b want 010", in_tready_b); end
        tick();
        n_checks++; if (wr_outstanding_b !== 2'd2 || out_tvalid_b !== 1'b1) begin n_fail++; $display("FAIL wrlim_resume: got cnt=%0d v=%b want cnt=2 v=1", wr_outstanding_b, out_tvalid_b); end
        n_checks++; if (err_commit_underflow_b !== 1'b0) begin n_fail++; $display("FAIL wrlim_err: got %b want 0", err_commit_underflow_b); end
        clear_inputs();
    endtask

    task automatic test_underflow();
        do_reset();
        out_tready = 1'b1;
        rx_commit_tvalid = 1'b1;
        tick();
        rx_commit_tvalid = 1'b0;
        n_checks++; if (wr_outstanding !== 7'd0 || err_commit_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow: got cnt=%0d err=%b want cnt=0 err=1", wr_outstanding, err_commit_underflow); end
        tick();
        n_checks++; if (err_commit_underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b want 1", err_commit_underflow); end
        set_src(1, 1'b1, 1'b1, tg(1, 0));
        repeat (5) tick();
        n_checks++; if (wr_outstanding !== 7'd5) begin n_fail++; $display("FAIL wr_count5: got %0d want 5", wr_outstanding); end
        rx_commit_tvalid = 1'b1;
        #1;
        n_checks++; if (in_tready !== 3'b010) begin n_fail++; $display("FAIL simul_rdy: got %b want 010", in_tready); end
        tick();
        n_checks++; if (wr_outstanding !== 7'd5) begin n_fail++; $display("FAIL simul_inc_dec: got %0d want 5", wr_outstanding); end
        set_src(1, 1'b0, 1'b0, '0);
        tick();
        rx_commit_tvalid = 1'b0;
        n_checks++; if (wr_outstanding !== 7'd4) begin n_fail++; $display("FAIL commit_dec: got %0d want 4", wr_outstanding); end
        do_reset();
        n_checks++; if (err_commit_underflow !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err_commit_underflow); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_tready = 1'b0;
        set_src(2, 1'b1, 1'b0, tg(2, 0));
        #1;
        n_checks++; if (in_tready !== 3'b100) begin n_fail++; $display("FAIL bp_first_rdy: got %b want 100", in_tready); end
        tick();
        n_checks++; if (out_tvalid !== 1'b1 || out_tuser !== tg(2, 0)) begin n_fail++; $display("FAIL bp_first_out: got v=%b u=%0d want v=1 u=%0d", out_tvalid, out_tuser, tg(2, 0)); end
        set_src(2, 1'b1, 1'b0, tg(2, 1));
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (in_tready !== 3'b000) begin n_fail++; $display("FAIL bp_hold_rdy k%0d: got %b want 000", k, in_tready); end
            tick();
            n_checks++; if (out_tvalid !== 1'b1 || out_tuser !== tg(2, 0) || out_tdata[31:0] !== {22'b0, tg(2, 0)}) begin n_fail++; $display("FAIL bp_hold_out k%0d: got v=%b u=%0d d=%h want v=1 u=%0d", k, out_tvalid, out_tuser, out_tdata[31:0], tg(2, 0)); end
        end
        out_tready = 1'b1;
        #1;
        n_checks++; if (in_tready !== 3'b100) begin n_fail++; $display("FAIL bp_release_rdy: got %b want 100", in_tready); end
        tick();
        n_checks++; if (out_tuser !== tg(2, 1)) begin n_fail++; $display("FAIL bp_release_out: got %0d want %0d", out_tuser, tg(2, 1)); end
        set_src(2, 1'b1, 1'b0, tg(2, 2));
        rst = 1'b1;
        #1;
        n_checks++; if (in_tready !== 3'b000) begin n_fail++; $display("FAIL midrst_rdy: got %b want 000", in_tready); end
        tick();
        n_checks++; if (out_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got %b want 0", out_tvalid); end
        rst = 1'b0;
        set_src(0, 1'b1, 1'b1, tg(0, 0));
        #1;
        n_checks++; if (in_tready !== 3'b001) begin n_fail++; $display("FAIL midrst_idle_rdy: got %b want 001", in_tready); end
        tick();
        n_checks++; if (out_tvalid !== 1'b1 || out_tuser !== tg(0, 0)) begin n_fail++; $display("FAIL midrst_sop: got v=%b u=%0d want v=1 u=%0d", out_tvalid, out_tuser, tg(0, 0)); end
        clear_inputs();
    endtask

    task automatic test_prio();
        int e;
        logic [NS-1:0] exp_rdy;
        do_reset();
        out_tready = 1'b1;
        set_src(0, 1'b1, 1'b1, tg(0, 0));
        set_src(2, 1'b1, 1'b1, tg(2, 0));
        for (int n = 0; n < 4; n++) begin
`ifdef TX_A_ARB_MMIO_PRIO_EN
            e = 0;
`else
            e = (n % 2 == 0) ? 0 : 2;
`endif
            exp_rdy = 3'b001 << e;
            #1;
            n_checks++; if (in_tready !== exp_rdy) begin n_fail++; $display("FAIL prio_rdy n%0d: got %b want %b", n, in_tready, exp_rdy); end
            tick();
            n_checks++; if (out_tuser !== tg(e, 0)) begin n_fail++; $display("FAIL prio_out n%0d: got %0d want %0d", n, out_tuser, tg(e, 0)); end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        out_tready = 1'b0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_atomic();
        test_wr_limit();
        test_underflow();
        test_backpressure();
        test_prio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_a_pkt_arbiter.md
TX_A_PKT_ARBITER -- requirements
Module: tx_a_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: number of TX requester streams merged onto TX-A.
REQ-002 SHALL have parameter DATA_W, default 512: tdata width; KEEP_W = DATA_W/8 is derived.
REQ-003 SHALL have parameter USER_W, default 10: tuser_vendor width.
REQ-004 SHALL have parameter WR_SRC_MASK, default 3'b010: bit i set means source i carries posted writes subject to commit tracking.
REQ-005 SHALL have parameter MAX_WR_OUTSTANDING, default 64: limit on uncommitted write packets; counter width is $clog2(MAX_WR_OUTSTANDING+1).
REQ-006 SHALL have port clk, input, 1: sole clock; all logic is posedge clk.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have ports in_tvalid/in_tlast, input, NUM_SRC: per-source valid and end-of-packet.
REQ-009 SHALL have ports in_tdata (NUM_SRC*DATA_W), in_tkeep (NUM_SRC*KEEP_W), in_tuser (NUM_SRC*USER_W), input: flattened per-source payload, with source i at slice i.
REQ-010 SHALL have port in_tready, output, NUM_SRC: per-source ready.
REQ-011 SHALL have ports out_tvalid, out_tlast (1), out_tdata (DATA_W), out_tkeep (KEEP_W), out_tuser (USER_W), output; and out_tready, input, 1: the TX-A stream.
REQ-012 SHALL have ports rx_commit_tvalid, input, 1; rx_commit_tready, output, 1: the write-commit stream (single-beat packets).
REQ-013 SHALL have ports wr_outstanding, output, counter width; err_commit_underflow, output, 1: status outputs.

Function
REQ-014 SHALL be packet-atomic: two states, IDLE and LOCKED; once a source's first beat is accepted, only that source is served until its tlast beat is accepted.
REQ-015 In IDLE, arbitration SHALL be combinational over eligible sources (in_tvalid set and, for WR_SRC_MASK sources, wr_outstanding < MAX_WR_OUTSTANDING), and SHALL be round-robin, searching from last_grant+1 with wrap-around at NUM_SRC-1 to 0.
REQ-016 An accepted beat in IDLE with tlast=0 SHALL move the FSM to LOCKED with lock_idx equal to the granted source; an accepted beat with tlast=1 SHALL leave it in IDLE; last_grant SHALL update on every accepted SOP beat.
REQ-017 In LOCKED, an accepted beat with tlast=1 SHALL return the FSM to IDLE; eligibility SHALL NOT be re-evaluated mid-packet.
REQ-018 The output SHALL be a single register stage, giving 1-cycle latency from input acceptance to out_tvalid; in_tready[i] = (i == granted/locked source) && (!out_tvalid || out_tready); all other in_tready bits SHALL be 0.
REQ-019 out_tvalid SHALL hold, with payload stable, until out_tready is asserted; back-to-back beats SHALL sustain one beat per cycle when out_tready=1.
REQ-020 wr_outstanding SHALL increment on acceptance of the SOP beat from a WR_SRC_MASK source, and SHALL decrement when rx_commit_tvalid=1; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-021 rx_commit_tready SHALL be constant 1.
REQ-022 A commit arriving while wr_outstanding=0 with no simultaneous increment SHALL leave the count at 0 and SHALL set err_commit_underflow (sticky until rst).
REQ-023 A write source SHALL NOT be granted at SOP while wr_outstanding == MAX_WR_OUTSTANDING; a packet already LOCKED SHALL complete regardless of the count.

Reset
REQ-024 While rst=1: FSM=IDLE, last_grant=NUM_SRC-1 (so source 0 is searched first), out_tvalid=0, in_tready=0, wr_outstanding=0, err_commit_underflow=0; payload registers are don't-care.
REQ-025 rst asserted mid-packet SHALL drop the partial packet and any registered beat; after rst deasserts, the next accepted beat is treated as SOP.

Configuration
REQ-026 Macro TX_A_ARB_MMIO_PRIO_EN: when defined, source 0 (MMIO responses) SHALL win every IDLE arbitration in which it is eligible, with round-robin applying only among sources 1..NUM_SRC-1; when undefined, all sources SHALL be pure round-robin per REQ-015. Packet atomicity SHALL hold in both cases.

Verification
REQ-027 All three sources continuously valid with 1-beat packets and out_tready=1 -> grant order 0,1,2,0,1,2; one beat per cycle.
REQ-028 Source 1 sends a 4-beat packet while source 0 becomes valid at beat 2 -> source 0 is held off until source 1's tlast is accepted, then granted next.
REQ-029 MAX_WR_OUTSTANDING=2; source 1 sends three 1-beat writes with no commits -> third stalls with in_tready[1]=0 and wr_outstanding=2; one rx_commit pulse -> third accepted, count stays 2.
REQ-030 Commit pulse with wr_outstanding=0 -> count stays 0, err_commit_underflow=1; SOP write and commit in the same cycle at count 5 -> count stays 5.
REQ-031 out_tready held 0 for 3 cycles with a beat registered -> out_* stable and in_tready all 0; rst asserted mid-packet -> out_tvalid=0 next cycle, FSM IDLE.
REQ-032 With TX_A_ARB_MMIO_PRIO_EN defined and sources 0 and 2 continuously valid with 1-beat packets -> source 0 is granted every cycle; undefined -> 0 and 2 alternate.
